// File: rtl/wb_pkg.sv
// Shared constants and types for the Wishbone burst master: cycle-type tags,
// FSM state encoding and completion status codes.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_WAITD = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Cycle type for beat index `beat` of a command carrying len+1 beats.
  function automatic logic [2:0] cti_for(input int unsigned beat, input int unsigned len);
    if (len == 0)        return CTI_CLASSIC;
    else if (beat >= len) return CTI_EOB;
    else                 return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_tmo_cnt.sv
// Counts consecutive cycles spent waiting on the slave; expire fires on the
// TMO-th such cycle so the master can abandon the bus cycle.
module wb_tmo_cnt #(
  parameter int TMO = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign expire = en & ~clr & (cnt == CW'(TMO - 1));

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 master turning a command + write-data stream into single or
// incrementing-burst bus cycles, returning read data and a completion status.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8,
  parameter int TMO  = 1023
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  input  logic [DW-1:0]     wdat,
  output logic              rdat_valid,
  output logic [DW-1:0]     rdat,
  output logic              done,
  output logic [1:0]        err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic [1:0]        dbg_state
);

  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  // Handshakes: cmd and wdat transfer on a rising edge where valid and ready
  // are both high; valid must hold with stable payload until that edge.
  // rdat has no ready, so the consumer must take every rdat_valid beat.

  state_t          state;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] beat_cnt;
  logic            last_beat;
  logic            cmd_go;
  logic            tmo_clr;
  logic            tmo_en;
  logic            tmo_expire;

  assign last_beat = (beat_cnt == len_r);
  assign cmd_go    = cmd_ready & cmd_valid;
  assign tmo_en    = (state == ST_BUS);
  assign tmo_clr   = (state != ST_BUS) | wb_ack_i | wb_err_i;
  assign wb_bte_o  = BTE_LINEAR;
  assign dbg_state = state;

  wb_tmo_cnt #(.TMO(TMO)) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // A write beat is taken exactly on the edge that (re)launches STB for it.
  always_comb begin
    wdat_ready = 1'b0;
    if (!wb_rst_i) begin
      case (state)
        ST_IDLE:  wdat_ready = cmd_ready & cmd_valid & cmd_we;
        ST_WAITD: wdat_ready = 1'b1;
        ST_BUS:   wdat_ready = wb_we_o & wb_ack_i & ~wb_err_i & ~last_beat;
        default:  wdat_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b0;
      len_r      <= '0;
      beat_cnt   <= '0;
      rdat_valid <= 1'b0;
      rdat       <= '0;
      done       <= 1'b0;
      err        <= ERR_OK;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      wb_cti_o   <= CTI_CLASSIC;
    end else begin
      rdat_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_go) begin
            cmd_ready <= 1'b0;
            len_r     <= cmd_len;
            beat_cnt  <= '0;
            wb_adr_o  <= cmd_addr;
            wb_sel_o  <= cmd_sel;
            wb_we_o   <= cmd_we;
            wb_cti_o  <= cti_for(32'd0, 32'(cmd_len));
            if (!cmd_we || wdat_valid) begin
              state    <= ST_BUS;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              if (cmd_we) wb_dat_o <= wdat;
            end else begin
              state <= ST_WAITD;
            end
          end
        end

        ST_WAITD: begin
          if (wdat_valid) begin
            state    <= ST_BUS;
            wb_dat_o <= wdat;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
          end
        end

        ST_BUS: begin
          if (wb_err_i) begin
            state    <= ST_FIN;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            done     <= 1'b1;
            err      <= ERR_BUS;
          end else if (wb_ack_i) begin
            wb_adr_o <= wb_adr_o + STEP;
            if (!wb_we_o) begin
              rdat_valid <= 1'b1;
              rdat       <= wb_dat_i;
            end
            if (last_beat) begin
              state    <= ST_FIN;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              done     <= 1'b1;
              err      <= ERR_OK;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              wb_cti_o <= cti_for(32'(beat_cnt) + 32'd1, 32'(len_r));
              // Write data starved: keep CYC so the burst stays owned.
              if (wb_we_o && !wdat_valid) begin
                state    <= ST_WAITD;
                wb_stb_o <= 1'b0;
              end else if (wb_we_o) begin
                wb_dat_o <= wdat;
              end
            end
          end else if (tmo_expire) begin
            state    <= ST_FIN;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            done     <= 1'b1;
            err      <= ERR_TMO;
          end
        end

        ST_FIN: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
